// File: rtl/eth_10g_send_to_10gmac.sv
// eth_10g_send_to_10gmac
// Transmit-side mate of the 10G receive parser. It builds Ethernet/IPv4/UDP
// frames from a show-ahead payload FIFO and drives the 10G MAC Avalon-ST TX
// port with 64-bit beats, first byte on [63:56]. The MAC appends the FCS and
// pads frames shorter than 60 bytes.
//
// Build option: define ETH_TX_ARP_REPLY_EN to include the ARP reply path.
// Without it, arp_op is ignored and only UDP frames are produced.
module eth_10g_send_to_10gmac #(
    parameter logic [15:0] SRC_PORT  = 16'd1234,
    parameter logic [15:0] DST_PORT  = 16'd1234,
    parameter logic [7:0]  TTL       = 8'h40,
    parameter logic [7:0]  MAX_WORDS = 8'd184
) (
    input  logic        clk_156_25,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [7:0]  tx_len,
    input  logic        arp_op,
    input  logic [47:0] mac_src_addr,
    input  logic [47:0] mac_dst_addr,
    input  logic [31:0] ip_src_addr,
    input  logic [31:0] ip_dst_addr,
    input  logic [63:0] rd_data,
    input  logic        rd_empty,
    output logic        rd_req,
    input  logic        avalon_st_tx_ready,
    output logic        avalon_st_tx_valid,
    output logic        avalon_st_tx_startofpacket,
    output logic        avalon_st_tx_endofpacket,
    output logic [63:0] avalon_st_tx_data,
    output logic [2:0]  avalon_st_tx_empty,
    output logic        avalon_st_tx_error,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM1,
        S_CSUM2,
        S_HDR,
        S_PAY,
        S_TAIL
`ifdef ETH_TX_ARP_REPLY_EN
        , S_ARP
`endif
    } state_t;

    state_t      state;
    logic [2:0]  beat_idx;
    logic [7:0]  pay_cnt;
    logic [7:0]  len_r;
    logic [7:0]  len_pend;
    logic        udp_pend;
    logic [15:0] ip_id;
    logic [31:0] csum_sum;
    logic [15:0] hdr_csum;
    logic [15:0] prev;

    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [31:0] csum_in;
    logic        accept;

`ifdef ETH_TX_ARP_REPLY_EN
    logic        arp_pend;
`else
    logic        unused_arp;
    assign unused_arp = arp_op;
`endif

    // Fold the 32-bit ones-complement sum twice and invert it.
    function automatic logic [15:0] csum_fold(input logic [31:0] s);
        logic [16:0] f1;
        logic [16:0] f2;
        f1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        f2 = {1'b0, f1[15:0]} + {16'h0, f1[16]};
        return ~f2[15:0];
    endfunction

    assign total_len = 16'd28 + {5'd0, len_r, 3'd0};
    assign udp_len   = 16'd8  + {5'd0, len_r, 3'd0};

    // Ten IPv4 header halfwords with the checksum field taken as zero.
    assign csum_in = 32'h0000_4500 + {16'h0, total_len} + {16'h0, ip_id}
                   + 32'h0000_4000 + {16'h0, TTL, 8'h11}
                   + {16'h0, ip_src_addr[31:16]} + {16'h0, ip_src_addr[15:0]}
                   + {16'h0, ip_dst_addr[31:16]} + {16'h0, ip_dst_addr[15:0]};

    assign accept             = avalon_st_tx_valid && avalon_st_tx_ready;
    assign rd_req             = (state == S_PAY) && accept;
    assign avalon_st_tx_error = 1'b0;

    // Beat decode: outputs depend only on registered state (and the FIFO head
    // in PAY), so they stay stable while the MAC withholds ready.
    always_comb begin
        avalon_st_tx_valid         = 1'b0;
        avalon_st_tx_startofpacket = 1'b0;
        avalon_st_tx_endofpacket   = 1'b0;
        avalon_st_tx_data          = 64'h0;
        avalon_st_tx_empty         = 3'd0;
        case (state)
            S_HDR: begin
                avalon_st_tx_valid         = 1'b1;
                avalon_st_tx_startofpacket = (beat_idx == 3'd0);
                case (beat_idx)
                    3'd0:    avalon_st_tx_data = {mac_dst_addr, mac_src_addr[47:32]};
                    3'd1:    avalon_st_tx_data = {mac_src_addr[31:0], 16'h0800, 16'h4500};
                    3'd2:    avalon_st_tx_data = {total_len, ip_id, 16'h4000, TTL, 8'h11};
                    3'd3:    avalon_st_tx_data = {hdr_csum, ip_src_addr, ip_dst_addr[31:16]};
                    3'd4:    avalon_st_tx_data = {ip_dst_addr[15:0], SRC_PORT, DST_PORT, udp_len};
                    default: avalon_st_tx_data = 64'h0;
                endcase
            end
            S_PAY: begin
                // The first beat's top halfword is the zero UDP checksum.
                avalon_st_tx_valid = !rd_empty;
                avalon_st_tx_data  = {prev, rd_data[63:16]};
            end
            S_TAIL: begin
                avalon_st_tx_valid       = 1'b1;
                avalon_st_tx_data        = {prev, 48'h0};
                avalon_st_tx_endofpacket = 1'b1;
                avalon_st_tx_empty       = 3'd6;
            end
`ifdef ETH_TX_ARP_REPLY_EN
            S_ARP: begin
                avalon_st_tx_valid         = 1'b1;
                avalon_st_tx_startofpacket = (beat_idx == 3'd0);
                case (beat_idx)
                    3'd0:    avalon_st_tx_data = {mac_dst_addr, mac_src_addr[47:32]};
                    3'd1:    avalon_st_tx_data = {mac_src_addr[31:0], 16'h0806, 16'h0001};
                    3'd2:    avalon_st_tx_data = {16'h0800, 8'h06, 8'h04, 16'h0002, mac_src_addr[47:32]};
                    3'd3:    avalon_st_tx_data = {mac_src_addr[31:0], ip_src_addr};
                    3'd4:    avalon_st_tx_data = {mac_dst_addr, ip_dst_addr[31:16]};
                    3'd5: begin
                        avalon_st_tx_data        = {ip_dst_addr[15:0], 48'h0};
                        avalon_st_tx_endofpacket = 1'b1;
                        avalon_st_tx_empty       = 3'd6;
                    end
                    default: avalon_st_tx_data = 64'h0;
                endcase
            end
`endif
            default: ;
        endcase
    end

    // Frame sequencer: request latching, checksum, beat stepping and done/busy.
    always_ff @(posedge clk_156_25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_idx <= 3'd0;
            pay_cnt  <= 8'd0;
            len_r    <= 8'd0;
            len_pend <= 8'd0;
            udp_pend <= 1'b0;
            ip_id    <= 16'h0;
            csum_sum <= 32'h0;
            hdr_csum <= 16'h0;
            prev     <= 16'h0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
`ifdef ETH_TX_ARP_REPLY_EN
            arp_pend <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef ETH_TX_ARP_REPLY_EN
                    // ARP replies win over a pending UDP frame.
                    if (arp_pend) begin
                        arp_pend <= 1'b0;
                        beat_idx <= 3'd0;
                        tx_busy  <= 1'b1;
                        state    <= S_ARP;
                    end else
`endif
                    if (udp_pend) begin
                        udp_pend <= 1'b0;
                        // Zero or oversized lengths are discarded silently.
                        if (len_pend != 8'd0 && len_pend <= MAX_WORDS) begin
                            len_r   <= len_pend;
                            tx_busy <= 1'b1;
                            state   <= S_CSUM1;
                        end
                    end
                end
                S_CSUM1: begin
                    csum_sum <= csum_in;
                    state    <= S_CSUM2;
                end
                S_CSUM2: begin
                    hdr_csum <= csum_fold(csum_sum);
                    beat_idx <= 3'd0;
                    state    <= S_HDR;
                end
                S_HDR: begin
                    if (accept) begin
                        if (beat_idx == 3'd4) begin
                            pay_cnt <= 8'd0;
                            prev    <= 16'h0;
                            state   <= S_PAY;
                        end else begin
                            beat_idx <= beat_idx + 3'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        prev <= rd_data[15:0];
                        if (pay_cnt == len_r - 8'd1) begin
                            state <= S_TAIL;
                        end else begin
                            pay_cnt <= pay_cnt + 8'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (accept) begin
                        ip_id   <= ip_id + 16'd1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
`ifdef ETH_TX_ARP_REPLY_EN
                S_ARP: begin
                    if (accept) begin
                        if (beat_idx == 3'd5) begin
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            beat_idx <= beat_idx + 3'd1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
            // New pulses land after the IDLE consume so a same-cycle request is kept.
            if (tx_start) begin
                udp_pend <= 1'b1;
                len_pend <= tx_len;
            end
`ifdef ETH_TX_ARP_REPLY_EN
            if (arp_op) begin
                arp_pend <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_eth_10g_send_to_10gmac.sv
// Scoreboard bench for eth_10g_send_to_10gmac: directed frames with
// hand-computed beats, backpressure, FIFO starvation, ARP priority and reset.
module tb_eth_10g_send_to_10gmac;

    logic        clk_156_25 = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [7:0]  tx_len;
    logic        arp_op;
    logic [47:0] mac_src_addr;
    logic [47:0] mac_dst_addr;
    logic [31:0] ip_src_addr;
    logic [31:0] ip_dst_addr;
    logic [63:0] rd_data;
    logic        rd_empty;
    logic        rd_req;
    logic        ready;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [63:0] data;
    logic [2:0]  empty;
    logic        err;
    logic        tx_busy;
    logic        tx_done;

    typedef logic [68:0] beat_t;

    beat_t       exp_q[$];
    logic [63:0] fifo[$];
    logic        fifo_empty_r = 1'b1;
    logic        hold_empty   = 1'b0;
    logic        rnd_ready    = 1'b0;
    logic        ready_fix    = 1'b1;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int pop_cnt  = 0;
    int rdreq_empty_cnt = 0;
    int hold_vld = 0;
    int hold_low = 0;
    int busy_seen = 0;
    logic  stalled = 1'b0;
    logic [69:0] held;

    assign rd_empty = fifo_empty_r | hold_empty;

    always #5 clk_156_25 = ~clk_156_25;

    eth_10g_send_to_10gmac dut (
        .clk_156_25                 (clk_156_25),
        .rst_n                      (rst_n),
        .tx_start                   (tx_start),
        .tx_len                     (tx_len),
        .arp_op                     (arp_op),
        .mac_src_addr               (mac_src_addr),
        .mac_dst_addr               (mac_dst_addr),
        .ip_src_addr                (ip_src_addr),
        .ip_dst_addr                (ip_dst_addr),
        .rd_data                    (rd_data),
        .rd_empty                   (rd_empty),
        .rd_req                     (rd_req),
        .avalon_st_tx_ready         (ready),
        .avalon_st_tx_valid         (valid),
        .avalon_st_tx_startofpacket (sop),
        .avalon_st_tx_endofpacket   (eop),
        .avalon_st_tx_data          (data),
        .avalon_st_tx_empty         (empty),
        .avalon_st_tx_error         (err),
        .tx_busy                    (tx_busy),
        .tx_done                    (tx_done)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em);
        return {d, s, e, em};
    endfunction

    // Expected UDP frame with payload W0..W2 (3 words).
    task automatic push_udp(input logic [15:0] id, input logic [15:0] csum);
        exp_q.push_back(mk(64'h66778899AABB0011, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h2233445508004500, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk({16'h0034, id, 32'h40004011}, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk({csum, 48'hC0A8010AC0A8}, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h011404D204D20020, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0000010203040506, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0708111213141516, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h1718212223242526, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h2728000000000000, 1'b0, 1'b1, 3'd6));
    endtask

    task automatic push_arp();
        exp_q.push_back(mk(64'h66778899AABB0011, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h2233445508060001, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0800060400020011, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h22334455C0A8010A, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h66778899AABBC0A8, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0114000000000000, 1'b0, 1'b1, 3'd6));
    endtask

    task automatic load_fifo();
        fifo.push_back(64'h0102030405060708);
        fifo.push_back(64'h1112131415161718);
        fifo.push_back(64'h2122232425262728);
    endtask

    task automatic pulse(input logic udp, input logic arp, input logic [7:0] len);
        @(posedge clk_156_25);
        #2;
        tx_start = udp;
        arp_op   = arp;
        tx_len   = len;
        @(posedge clk_156_25);
        #2;
        tx_start = 1'b0;
        arp_op   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk_156_25);
        end
        check(name, 72'(done_cnt >= target), 72'd1);
    endtask

    // Ready driver: fixed or 50% random, changed just after each edge.
    always @(posedge clk_156_25) begin
        #1;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    // Show-ahead FIFO model: pop on rd_req at the edge, present the new head.
    always @(posedge clk_156_25) begin
        if (rd_req) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_cnt++;
        end
        #1;
        fifo_empty_r = (fifo.size() == 0);
        rd_data      = (fifo.size() > 0) ? fifo[0] : 64'h0;
    end

    // Monitor: compares accepted beats against the scoreboard and watches stalls.
    always @(negedge clk_156_25) begin
        if (rst_n) begin
            if (tx_done) done_cnt++;
            if (tx_busy) busy_seen++;
            if (rd_req && rd_empty) rdreq_empty_cnt++;
            if (hold_empty) begin
                if (valid) hold_vld++;
                else hold_low++;
            end
            if (stalled) check("hold_stable", 72'({valid, data, sop, eop, empty}), 72'(held));
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat actual=%h required=none", {data, sop, eop, empty});
                end else begin
                    check("beat", 72'({data, sop, eop, empty}), 72'(exp_q.pop_front()));
                end
            end
            stalled = valid && !ready;
            held    = {valid, data, sop, eop, empty};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int p0;
        int d0;
        rst_n        = 1'b0;
        tx_start     = 1'b0;
        arp_op       = 1'b0;
        tx_len       = 8'd0;
        ready        = 1'b1;
        rd_data      = 64'h0;
        mac_src_addr = 48'h001122334455;
        mac_dst_addr = 48'h66778899AABB;
        ip_src_addr  = 32'hC0A8010A;
        ip_dst_addr  = 32'hC0A80114;
        repeat (3) @(posedge clk_156_25);
        #1;
        check("rst_valid", 72'(valid), 72'd0);
        check("rst_data", 72'({data, sop, eop, empty, err}), 72'd0);
        check("rst_rdreq", 72'(rd_req), 72'd0);
        check("rst_busy_done", 72'({tx_busy, tx_done}), 72'd0);
        @(posedge clk_156_25);
        #2;
        rst_n = 1'b1;

        // Frame 1: no backpressure, ip_id 0.
        load_fifo();
        push_udp(16'h0000, 16'hB74A);
        p0 = pop_cnt;
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 8'd3);
        wait_done("f1_done_wait", d0 + 1);
        repeat (5) @(posedge clk_156_25);
        check("f1_pops", 72'(pop_cnt - p0), 72'd3);
        check("f1_done_cnt", 72'(done_cnt - d0), 72'd1);
        check("f1_busy_after", 72'(tx_busy), 72'd0);
        check("f1_queue_empty", 72'(exp_q.size()), 72'd0);

        // Frame 2: random backpressure, ip_id 1.
        load_fifo();
        push_udp(16'h0001, 16'hB749);
        rnd_ready = 1'b1;
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 8'd3);
        wait_done("f2_done_wait", d0 + 1);
        rnd_ready = 1'b0;
        repeat (5) @(posedge clk_156_25);
        check("f2_queue_empty", 72'(exp_q.size()), 72'd0);

        // Frame 3: FIFO starved for 5 cycles after the first payload pop.
        load_fifo();
        push_udp(16'h0002, 16'hB748);
        p0 = pop_cnt;
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_156_25);
            #1;
            if (pop_cnt > p0) break;
        end
        check("f3_first_pop", 72'(pop_cnt - p0), 72'd1);
        #1;
        hold_empty = 1'b1;
        repeat (5) @(posedge clk_156_25);
        #2;
        hold_empty = 1'b0;
        wait_done("f3_done_wait", d0 + 1);
        repeat (5) @(posedge clk_156_25);
        check("f3_valid_in_hold", 72'(hold_vld), 72'd0);
        check("f3_low_in_hold", 72'(hold_low), 72'd5);
        check("f3_pops", 72'(pop_cnt - p0), 72'd3);

        // ARP and UDP in the same cycle: ARP first (when built), then UDP ip_id 3.
        load_fifo();
`ifdef ETH_TX_ARP_REPLY_EN
        push_arp();
`endif
        push_udp(16'h0003, 16'hB747);
        d0 = done_cnt;
        pulse(1'b1, 1'b1, 8'd3);
`ifdef ETH_TX_ARP_REPLY_EN
        wait_done("arp_udp_done_wait", d0 + 2);
        repeat (5) @(posedge clk_156_25);
        check("arp_udp_done_cnt", 72'(done_cnt - d0), 72'd2);
`else
        wait_done("arp_udp_done_wait", d0 + 1);
        repeat (5) @(posedge clk_156_25);
        check("arp_udp_done_cnt", 72'(done_cnt - d0), 72'd1);
`endif
        check("arp_udp_queue_empty", 72'(exp_q.size()), 72'd0);

        // Length 0 and length above MAX_WORDS are dropped.
        busy_seen = 0;
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 8'd0);
        repeat (20) @(posedge clk_156_25);
        pulse(1'b1, 1'b0, 8'd185);
        repeat (20) @(posedge clk_156_25);
        check("drop_busy", 72'(busy_seen), 72'd0);
        check("drop_done", 72'(done_cnt - d0), 72'd0);

        // Reset during payload beat 2 truncates the frame (ip_id 4 header).
        load_fifo();
        exp_q.push_back(mk(64'h66778899AABB0011, 1'b1, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h2233445508004500, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0034000440004011, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'hB746C0A8010AC0A8, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h011404D204D20020, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0000010203040506, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(64'h0708111213141516, 1'b0, 1'b0, 3'd0));
        p0 = pop_cnt;
        pulse(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_156_25);
            #1;
            if (pop_cnt >= p0 + 2) break;
        end
        check("rst_mid_pops", 72'(pop_cnt - p0), 72'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 72'({valid, sop, eop}), 72'd0);
        check("rst_mid_data", 72'(data), 72'd0);
        check("rst_mid_ctrl", 72'({rd_req, tx_busy, tx_done}), 72'd0);
        check("rst_mid_queue", 72'(exp_q.size()), 72'd0);
        fifo.delete();
        repeat (3) @(posedge clk_156_25);
        #2;
        rst_n = 1'b1;

        // Clean frame after reset, ip_id back to 0.
        load_fifo();
        push_udp(16'h0000, 16'hB74A);
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 8'd3);
        wait_done("post_rst_done_wait", d0 + 1);
        repeat (5) @(posedge clk_156_25);
        check("post_rst_queue_empty", 72'(exp_q.size()), 72'd0);
        check("rdreq_while_empty", 72'(rdreq_empty_cnt), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
